// File: rtl/uart_rx_fifo_pkg.sv
// System-wide constants shared by the UART receive path and the bus decoder.
// Holds the FIFO count-width rule and the MMIO map through which software
// reaches the receive FIFO.
package uart_rx_fifo_pkg;

    // The occupancy counter needs one bit more than the pointers so that
    // "completely full" (count == DEPTH) is distinct from "empty" (count == 0).
    function automatic int fifoCountWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Reading the data address returns the head byte and pops it.
    localparam logic [11:0] UART_RX_DATA_ADDR   = 12'h400;

    // Reading the status address returns {overflow, underflow, full, !empty}.
    localparam logic [11:0] UART_RX_STATUS_ADDR = 12'h401;

    // Bit layout of the status word, MSB first, as seen by software.
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic full;
        logic notEmpty;
    } uartRxStatus_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO that sits between the UART receiver and the bus.
// First-word-fall-through: the head entry is always visible on O_data.
// Dropped pushes and ignored pops are recorded in sticky flags that
// software clears explicitly.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                               I_clk,
    input  logic                               I_reset,
    input  logic                               I_push,
    input  logic [WIDTH-1:0]                   I_data,
    input  logic                               I_pop,
    input  logic                               I_clear_flags,
    output logic [WIDTH-1:0]                   O_data,
    output logic                               O_empty,
    output logic                               O_full,
    output logic [fifoCountWidth(DEPTH)-1:0]   O_count,
    output logic                               O_overflow,
    output logic                               O_underflow
);

    localparam int PtrWidth   = $clog2(DEPTH);
    localparam int CountWidth = fifoCountWidth(DEPTH);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PtrWidth-1:0]   r_wp;
    logic [PtrWidth-1:0]   r_rp;
    logic [CountWidth-1:0] r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_isEmpty;
    logic w_isFull;
    logic w_popOk;
    logic w_pushOk;
    logic w_setOverflow;
    logic w_setUnderflow;

    // Accept/reject decisions; a pop on a full FIFO frees the slot that a
    // same-cycle push then takes, but an empty FIFO never bypasses.
    always_comb begin
        w_isEmpty      = (r_count == '0);
        w_isFull       = (r_count == FullCount);
        w_popOk        = I_pop && !w_isEmpty;
        w_pushOk       = I_push && (!w_isFull || w_popOk);
        w_setOverflow  = I_push && !w_pushOk;
        w_setUnderflow = I_pop && w_isEmpty;
    end

    // Storage array has no reset; stale contents are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge I_clk) begin
        if (!I_reset && w_pushOk) begin
            r_mem[r_wp] <= I_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at their bit width.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_popOk) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as a clear wins.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_setOverflow  || (r_overflow  && !I_clear_flags);
            r_underflow <= w_setUnderflow || (r_underflow && !I_clear_flags);
        end
    end

    // Outputs come straight from registered state, never from I_push/I_pop.
    always_comb begin
        O_data      = r_mem[r_rp];
        O_empty     = (r_count == '0);
        O_full      = (r_count == FullCount);
        O_count     = r_count;
        O_overflow  = r_overflow;
        O_underflow = r_underflow;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with DEPTH=16, WIDTH=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at
// the same point, i.e. after the edge has settled.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       push;
    logic [7:0] data;
    logic       pop;
    logic       clearFlags;
    logic [7:0] outData;
    logic       outEmpty;
    logic       outFull;
    logic [4:0] outCount;
    logic       outOverflow;
    logic       outUnderflow;

    int checks;
    int errors;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .I_clk         (clk),
        .I_reset       (reset),
        .I_push        (push),
        .I_data        (data),
        .I_pop         (pop),
        .I_clear_flags (clearFlags),
        .O_data        (outData),
        .O_empty       (outEmpty),
        .O_full        (outFull),
        .O_count       (outCount),
        .O_overflow    (outOverflow),
        .O_underflow   (outUnderflow)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, let the edge happen, then idle the strobes.
    task automatic applyStimulus(input logic rst, input logic ps, input logic [7:0] d,
                                 input logic pp, input logic clr);
        reset      = rst;
        push       = ps;
        data       = d;
        pop        = pp;
        clearFlags = clr;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clearFlags = 1'b0;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        push       = 1'b0;
        data       = 8'h00;
        pop        = 1'b0;
        clearFlags = 1'b0;

        // Reset, with a push and pop offered that must be ignored.
        applyStimulus(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("reset_empty",     32'(outEmpty),     32'd1);
        checkOutput("reset_full",      32'(outFull),      32'd0);
        checkOutput("reset_count",     32'(outCount),     32'd0);
        checkOutput("reset_overflow",  32'(outOverflow),  32'd0);
        checkOutput("reset_underflow", 32'(outUnderflow), 32'd0);

        // Three pushes then three pops.
        applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, 1'b0);
        checkOutput("first_push_empty", 32'(outEmpty), 32'd0);
        checkOutput("first_push_data",  32'(outData),  32'h41);
        applyStimulus(1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h43, 1'b0, 1'b0);
        checkOutput("three_count", 32'(outCount), 32'd3);
        checkOutput("three_head",  32'(outData),  32'h41);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pop1_head", 32'(outData), 32'h42);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pop2_head", 32'(outData), 32'h43);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("pop3_empty", 32'(outEmpty), 32'd1);
        checkOutput("pop3_count", 32'(outCount), 32'd0);

        // Seventeen pushes 0x00..0x10: full after 16, overflow on 17th.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 14) checkOutput("fill15_full", 32'(outFull), 32'd0);
        end
        checkOutput("fill16_full",     32'(outFull),     32'd1);
        checkOutput("fill16_count",    32'(outCount),    32'd16);
        checkOutput("fill16_overflow", 32'(outOverflow), 32'd0);
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
        checkOutput("push17_overflow", 32'(outOverflow), 32'd1);
        checkOutput("push17_count",    32'(outCount),    32'd16);
        checkOutput("push17_head",     32'(outData),     32'h00);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("drain17_%0d", i), 32'(outData), 32'(i));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("drain17_empty", 32'(outEmpty), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("clear_overflow", 32'(outOverflow), 32'd0);

        // Full FIFO with simultaneous push 0xAA and pop: no overflow.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
        checkOutput("fullpp_overflow", 32'(outOverflow), 32'd0);
        checkOutput("fullpp_count",    32'(outCount),    32'd16);
        checkOutput("fullpp_head",     32'(outData),     32'h21);
        for (int i = 1; i < 16; i++) begin
            checkOutput($sformatf("fullpp_drain_%0d", i), 32'(outData), 32'(8'h20 + i));
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("fullpp_last", 32'(outData), 32'hAA);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fullpp_empty", 32'(outEmpty), 32'd1);

        // Pop on empty, clear, then pop-on-empty together with clear.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("underflow_set",   32'(outUnderflow), 32'd1);
        checkOutput("underflow_count", 32'(outCount),     32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("underflow_clear", 32'(outUnderflow), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("underflow_setwins", 32'(outUnderflow), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("underflow_clear2", 32'(outUnderflow), 32'd0);

        // Push and pop together on empty: push only, underflow raised.
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
        checkOutput("emptypp_count",     32'(outCount),     32'd1);
        checkOutput("emptypp_underflow", 32'(outUnderflow), 32'd1);
        checkOutput("emptypp_head",      32'(outData),      32'h55);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Forty push/pop pairs at count=1 walk the pointers around twice.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            checkOutput($sformatf("wrap_count_%0d", i), 32'(outCount), 32'd1);
            checkOutput($sformatf("wrap_head_%0d", i),  32'(outData),  32'(8'h60 + i));
        end
        checkOutput("wrap_flags", 32'({outOverflow, outUnderflow}), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("wrap_empty", 32'(outEmpty), 32'd1);

        // Reset with five entries stored and a sticky flag raised.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        end
        checkOutput("prereset_count",     32'(outCount),     32'd5);
        checkOutput("prereset_underflow", 32'(outUnderflow), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hEE, 1'b0, 1'b0);
        checkOutput("midreset_empty",     32'(outEmpty),     32'd1);
        checkOutput("midreset_count",     32'(outCount),     32'd0);
        checkOutput("midreset_full",      32'(outFull),      32'd0);
        checkOutput("midreset_overflow",  32'(outOverflow),  32'd0);
        checkOutput("midreset_underflow", 32'(outUnderflow), 32'd0);

        // After reset the FIFO accepts fresh data from the cleared pointers.
        applyStimulus(1'b0, 1'b1, 8'h7E, 1'b0, 1'b0);
        checkOutput("postreset_head",  32'(outData),  32'h7E);
        checkOutput("postreset_count", 32'(outCount), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
